// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready on both sides, 2-entry skid buffer with a
// registered in_ready, synchronous flush (bubble insert) and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int                 DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}},
  parameter int                 CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              clr_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              in_fire;
  logic              out_fire;

  // Handshakes use only registered flags, so ready/valid never loop through this stage.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // The flags are computed from the next state so the ports come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= RST_VAL;
      skid_q      <= RST_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic scored
// against a queue-based model of the stage contents.
module tb_pipe_stage_elastic;

  localparam int DW = 32;
  localparam int CW = 3;
  localparam int CNT_SAT = (1 << CW) - 1;
  localparam logic [DW-1:0] RV = '0;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready, clr_cnt;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: held entries in FIFO order, bubble flag, stall count.
  logic [DW-1:0] mq[$];
  bit            bubble = 1'b1;
  int            mcnt = 0;

  pipe_stage_elastic #(.DATA_W(DW), .RST_VAL(RV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  // Apply inputs (called just after a falling edge), cross one rising edge,
  // advance the model, and return at the next falling edge.
  task automatic tick(input bit r, input bit f, input bit iv, input logic [DW-1:0] d,
                      input bit ordy, input bit clr);
    bit ifire, ofire;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy; clr_cnt = clr;
    ifire = iv && (mq.size() < 2);
    ofire = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      mq.delete(); bubble = 1'b1; mcnt = 0;
    end else begin
      if (clr) mcnt = 0;
      else if ((mq.size() > 0) && !ordy && (mcnt < CNT_SAT)) mcnt++;
      if (f) begin
        mq.delete(); bubble = 1'b1;
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) begin mq.push_back(d); bubble = 1'b0; end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick(1, 0, 0, '0, 0, 0);
    tick(0, 0, 0, '0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (out_data !== RV) begin n_bad++; $display("FAIL reset_out_data: got %h want %h", out_data, RV); end
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_stream;
    logic [DW-1:0] vals[3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, vals[i], 1, 0);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        n_bad++; $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, vals[i]);
      end
      n_cmp++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
        n_bad++; $display("FAIL stream_flags[%0d]: got rdy=%b occ=%0d want rdy=1 occ=1", i, in_ready, occupancy);
      end
    end
    tick(0, 0, 0, '0, 1, 0);
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_bad++; $display("FAIL stream_drain: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_back_pressure;
    tick(0, 0, 1, 32'hA1, 0, 0);
    n_cmp++; if (occupancy !== 2'd1 || out_data !== 32'hA1) begin
      n_bad++; $display("FAIL bp_first: got occ=%0d d=%h want occ=1 d=a1", occupancy, out_data);
    end
    tick(0, 0, 1, 32'hA2, 0, 0);
    n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA1) begin
      n_bad++; $display("FAIL bp_full: got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=a1", occupancy, in_ready, out_data);
    end
    tick(0, 0, 1, 32'hA3, 0, 0);
    n_cmp++; if (occupancy !== 2'd2 || out_data !== 32'hA1) begin
      n_bad++; $display("FAIL bp_reject: got occ=%0d d=%h want occ=2 d=a1", occupancy, out_data);
    end
    tick(0, 0, 0, '0, 1, 0);
    n_cmp++; if (occupancy !== 2'd1 || out_data !== 32'hA2 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: got occ=%0d d=%h rdy=%b want occ=1 d=a2 rdy=1", occupancy, out_data, in_ready);
    end
    tick(0, 0, 1, 32'hA3, 1, 0);
    n_cmp++; if (occupancy !== 2'd1 || out_data !== 32'hA3) begin
      n_bad++; $display("FAIL bp_resend: got occ=%0d d=%h want occ=1 d=a3", occupancy, out_data);
    end
    tick(0, 0, 0, '0, 1, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush;
    tick(0, 0, 1, 32'hB1, 0, 0);
    tick(0, 0, 1, 32'hB2, 0, 0);
    n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_prefill: got occ=%0d want 2", occupancy); end
    tick(0, 1, 1, 32'hB3, 0, 0);
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== RV || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_bubble: got occ=%0d v=%b d=%h rdy=%b want occ=0 v=0 d=%h rdy=1",
                        occupancy, out_valid, out_data, in_ready, RV);
    end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, '0, 1, 0);
    n_cmp++; if (out_valid !== 1'b0 || out_data !== RV) begin
      n_bad++; $display("FAIL flush_no_ghost: got v=%b d=%h want v=0 d=%h", out_valid, out_data, RV);
    end
  endtask

  task automatic test_stall_saturation;
    int want;
    tick(0, 0, 0, '0, 1, 1);
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL sat_clear0: got %0d want 0", stall_cnt); end
    tick(0, 0, 1, 32'hC1, 0, 0);
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL sat_fill: got %0d want 0", stall_cnt); end
    for (int k = 1; k <= 10; k++) begin
      tick(0, 0, 0, '0, 0, 0);
      want = (k < CNT_SAT) ? k : CNT_SAT;
      n_cmp++; if (int'(stall_cnt) != want || out_data !== 32'hC1) begin
        n_bad++; $display("FAIL sat_count[%0d]: got cnt=%0d d=%h want cnt=%0d d=c1", k, stall_cnt, out_data, want);
      end
    end
    tick(0, 0, 0, '0, 0, 1);
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL sat_clr_priority: got %0d want 0", stall_cnt); end
    tick(0, 1, 0, '0, 0, 0);
    n_cmp++; if (stall_cnt !== 3'd1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL sat_flush_keeps_cnt: got cnt=%0d v=%b want cnt=1 v=0", stall_cnt, out_valid);
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] want_d;
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        tick(1, 0, 1, $urandom, 0, 0);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
                     out_data !== RV || stall_cnt !== '0) begin
          n_bad++; $display("FAIL rand_mid_reset: got v=%b rdy=%b occ=%0d d=%h cnt=%0d want 0/1/0/%h/0",
                            out_valid, in_ready, occupancy, out_data, stall_cnt, RV);
        end
      end
      tick(0, ($urandom_range(99) < 2), $urandom_range(1), $urandom, $urandom_range(1),
           ($urandom_range(99) < 1));
      n_cmp++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                   int'(occupancy) != mq.size()) begin
        n_bad++; $display("FAIL rand_flags@%0d: got v=%b rdy=%b occ=%0d want occ=%0d",
                          c, out_valid, in_ready, occupancy, mq.size());
      end
      if (mq.size() > 0 || bubble) begin
        want_d = (mq.size() > 0) ? mq[0] : RV;
        n_cmp++; if (out_data !== want_d) begin
          n_bad++; $display("FAIL rand_data@%0d: got %h want %h", c, out_data, want_d);
        end
      end
      n_cmp++; if (int'(stall_cnt) != mcnt) begin
        n_bad++; $display("FAIL rand_stall@%0d: got %0d want %0d", c, stall_cnt, mcnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_stall_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
